// File: rtl/loader_pkg.sv
// Shared types and constants for the program-loader byte-stream producer.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_START,
        S_DATA,
        S_END
    } loader_state_t;

    localparam logic [7:0] LOADER_MAGIC     = 8'h99;
    localparam int         LOADER_HDR_BYTES = 3;

endpackage

// File: rtl/program_loader_tx.sv
// Parses magic / 16-bit BE word count / 4*N bytes from the UART and drives start/valid/end to the fetch loader.
// Latency: one cycle from rx_valid to input_valid; a byte landing in the start cycle is held and sent next cycle.
// No backpressure: accepts a byte every cycle; LOADER_TIMEOUT_EN adds an idle-byte timeout that aborts with error.
module program_loader_tx
    import loader_pkg::*;
#(
    parameter logic [7:0]  MAGIC          = LOADER_MAGIC,
    parameter int          LEN_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] input_data,
    output logic       input_valid,
    output logic       input_start,
    output logic       input_end,
    output logic       busy,
    output logic       error,
    output logic       done
);

    localparam int TW = LEN_WIDTH + 2;

    loader_state_t        state_q;
    logic [LEN_WIDTH-1:0] count_q;
    logic [TW-1:0]        sent_q;
    logic [7:0]           data_q;
    logic                 valid_q;
    logic                 start_q;
    logic                 end_q;
    logic                 busy_q;
    logic                 error_q;
    logic                 done_q;

    logic [TW-1:0]        target_d;
    logic [TW-1:0]        sent_d;
    logic                 tmo_hit_d;

    // Word count times four, widened so a full 16-bit count cannot wrap.
    assign target_d = {count_q, 2'b00};
    assign sent_d   = sent_q + TW'(1);

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit_d = !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (rx_valid || state_q == S_IDLE || state_q == S_START || state_q == S_END) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    assign tmo_hit_d = 1'b0;
`endif

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            sent_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid && rx_data == MAGIC) begin
                        state_q <= S_LEN_HI;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                    end
                end
                S_LEN_HI: begin
                    if (rx_valid) begin
                        count_q[LEN_WIDTH-1 -: 8] <= rx_data;
                        state_q                   <= S_LEN_LO;
                    end else if (tmo_hit_d) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (rx_valid) begin
                        count_q[7:0] <= rx_data;
                        sent_q       <= '0;
                        start_q      <= 1'b1;
                        state_q      <= S_START;
                    end else if (tmo_hit_d) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (target_d == '0) begin
                        end_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_END;
                    end else begin
                        // The output register doubles as the skid slot for a byte seen during start.
                        state_q <= S_DATA;
                        if (rx_valid) begin
                            data_q  <= rx_data;
                            valid_q <= 1'b1;
                            sent_q  <= sent_d;
                        end
                    end
                end
                S_DATA: begin
                    if (sent_q == target_d) begin
                        end_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_END;
                    end else if (rx_valid) begin
                        data_q  <= rx_data;
                        valid_q <= 1'b1;
                        sent_q  <= sent_d;
                    end else if (tmo_hit_d) begin
                        end_q   <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= S_END;
                    end
                end
                S_END: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign input_data  = data_q;
    assign input_valid = valid_q;
    assign input_start = start_q;
    assign input_end   = end_q;
    assign busy        = busy_q;
    assign error       = error_q;
    assign done        = done_q;

endmodule

// File: tb/tb_program_loader_tx.sv
// Self-checking bench for program_loader_tx: directed table, hand-written corner sequences, randomized frames.
module tb_program_loader_tx;
    import loader_pkg::*;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TB_TMO = 50;
`else
    localparam int unsigned TB_TMO = 1000000;
`endif

    logic       CLK = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] input_data;
    logic       input_valid;
    logic       input_start;
    logic       input_end;
    logic       busy;
    logic       error;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    program_loader_tx #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .input_data  (input_data),
        .input_valid (input_valid),
        .input_start (input_start),
        .input_end   (input_end),
        .busy        (busy),
        .error       (error),
        .done        (done)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // kind: 0 = start, 1 = valid, 2 = end
    typedef struct {
        int         kind;
        logic [7:0] dat;
        int         c;
    } ev_t;

    ev_t        got[$];
    ev_t        exp_q[$];
    logic [7:0] sb[$];
    int         sc[$];
    int         got_done;
    int         exp_frames;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (reset_n) begin
            ev_t e;
            int  s;
            s = int'(input_start) + int'(input_valid) + int'(input_end);
            if (input_start) begin e.kind = 0; e.dat = 8'h00;      e.c = cyc; got.push_back(e); end
            if (input_valid) begin e.kind = 1; e.dat = input_data; e.c = cyc; got.push_back(e); end
            if (input_end)   begin e.kind = 2; e.dat = 8'h00;      e.c = cyc; got.push_back(e); end
            if (s != 0) check("pulse_exclusive", s, 1);
            if (done) begin
                got_done++;
                check("done_with_end", {31'd0, input_end}, 1);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        sb.push_back(b);
        sc.push_back(cyc);
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (gap) tick();
    endtask

    task automatic clr();
        got.delete();
        sb.delete();
        sc.delete();
        got_done = 0;
    endtask

    // Frame-level reference: find magic, read length, each payload byte appears one cycle after it arrived.
    task automatic build_model();
        int i;
        int n;
        int scyc;
        int last;
        int idx;
        ev_t e;
        i = 0;
        exp_q.delete();
        exp_frames = 0;
        while (i < sb.size()) begin
            if (sb[i] != LOADER_MAGIC || i + 2 >= sb.size()) begin
                i++;
                continue;
            end
            n    = 4 * ((int'(sb[i+1]) << 8) + int'(sb[i+2]));
            scyc = sc[i+2] + 1;
            e.kind = 0; e.dat = 8'h00; e.c = scyc; exp_q.push_back(e);
            last = scyc;
            for (int k = 0; k < n; k++) begin
                idx = i + LOADER_HDR_BYTES + k;
                if (idx < sb.size()) begin
                    e.kind = 1; e.dat = sb[idx]; e.c = sc[idx] + 1; exp_q.push_back(e);
                    last = sc[idx] + 1;
                end
            end
            e.kind = 2; e.dat = 8'h00; e.c = last + 1; exp_q.push_back(e);
            exp_frames++;
            i = i + LOADER_HDR_BYTES + n;
        end
    endtask

    task automatic compare_streams(input string tag);
        build_model();
        check($sformatf("%s_nevents", tag), got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            check($sformatf("%s_kind%0d", tag, k), got[k].kind, exp_q[k].kind);
            check($sformatf("%s_data%0d", tag, k), {24'd0, got[k].dat}, {24'd0, exp_q[k].dat});
            check($sformatf("%s_cycle%0d", tag, k), got[k].c, exp_q[k].c);
        end
        check($sformatf("%s_done", tag), got_done, exp_frames);
        check($sformatf("%s_error", tag), {31'd0, error}, 0);
    endtask

    task automatic wait_quiet(input string tag);
        int t;
        t = 0;
        while (busy && t < 500) begin
            tick();
            t++;
        end
        check($sformatf("%s_finish_in_time", tag), {31'd0, (t < 500)}, 1);
        repeat (3) tick();
    endtask

    typedef struct {
        logic [95:0] bytes;
        int          len;
        int          gap;
        int          exp_nvalid;
        logic [31:0] exp_word;
        int          exp_done;
    } vec_t;

    vec_t vt[4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end

    initial begin
        int          nv;
        logic [31:0] w;
        int          nwords;
        int          ng;
        logic [7:0]  b;

        vt[0] = '{96'h99_0001_DEADBEEF,            7,  3, 4, 32'hDEADBEEF, 1};
        vt[1] = '{96'h99_0002_0102030405060708,   11,  0, 8, 32'h01020304, 1};
        vt[2] = '{96'h99_0000,                     3,  0, 0, 32'h00000000, 1};
        vt[3] = '{96'h1234_99_0001_11223344,       9,  1, 4, 32'h11223344, 1};

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        got_done = 0;
        repeat (3) tick();
        check("reset_outputs", {18'd0, input_data, input_valid, input_start, input_end, busy, error, done}, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 4; v++) begin
            clr();
            for (int k = 0; k < vt[v].len; k++)
                send(vt[v].bytes[8*(vt[v].len-1-k) +: 8], vt[v].gap);
            wait_quiet($sformatf("vec%0d", v));
            nv = 0;
            w  = '0;
            foreach (got[k]) begin
                if (got[k].kind == 1) begin
                    if (nv < 4) w = {w[23:0], got[k].dat};
                    nv++;
                end
            end
            check($sformatf("vec%0d_nvalid", v), nv, vt[v].exp_nvalid);
            check($sformatf("vec%0d_first_word", v), w, vt[v].exp_word);
            check($sformatf("vec%0d_done_count", v), got_done, vt[v].exp_done);
            check($sformatf("vec%0d_busy_idle", v), {31'd0, busy}, 0);
            compare_streams($sformatf("vec%0d", v));
        end

        // Reset in the middle of the payload: outputs drop at once, no end is ever produced.
        clr();
        send(8'h99, 0);
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'hA1, 0);
        send(8'hA2, 0);
        check("mid_load_valid", {31'd0, input_valid}, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {18'd0, input_data, input_valid, input_start, input_end, busy, error, done}, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        nv = 0;
        foreach (got[k]) if (got[k].kind == 2) nv++;
        check("reset_no_end", nv, 0);
        check("reset_idle_busy", {31'd0, busy}, 0);
        clr();
        send(8'h99, 0);
        send(8'h00, 1);
        send(8'h01, 0);
        for (int k = 0; k < 4; k++) send(8'($urandom_range(0, 255)), $urandom_range(0, 1));
        wait_quiet("post_reset");
        compare_streams("post_reset");

        for (int f = 0; f < 15; f++) begin
            clr();
            ng = $urandom_range(0, 2);
            for (int k = 0; k < ng; k++) begin
                b = 8'($urandom_range(0, 255));
                if (b == LOADER_MAGIC) b = 8'h98;
                send(b, $urandom_range(0, 2));
            end
            nwords = $urandom_range(0, 3);
            send(LOADER_MAGIC, $urandom_range(0, 2));
            send(8'h00, $urandom_range(0, 2));
            send(8'(nwords), $urandom_range(0, 2));
            for (int k = 0; k < 4 * nwords; k++)
                send(8'($urandom_range(0, 255)), $urandom_range(0, 2));
            wait_quiet($sformatf("rnd%0d", f));
            compare_streams($sformatf("rnd%0d", f));
        end

`ifdef LOADER_TIMEOUT_EN
        // Stall after three of four payload bytes: end after 50 idle cycles, error set, no done.
        clr();
        send(8'h99, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h5A, 0);
        send(8'h6B, 0);
        send(8'h7C, 0);
        wait_quiet("timeout");
        nv = -1;
        foreach (got[k]) if (got[k].kind == 2) nv = got[k].c;
        check("timeout_end_cycle", nv, sc[5] + 51);
        check("timeout_error", {31'd0, error}, 1);
        check("timeout_no_done", got_done, 0);
        send(8'h99, 0);
        check("magic_clears_error", {31'd0, error}, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        wait_quiet("timeout_recover");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader_tx.md
Name: program_loader_tx

Overview:
- Producer side of the instruction-memory program-loader stream.
- Sits between the UART receive byte path and the fetch stage's loader inputs (input_data / input_start / input_end / input_valid).
- Parses a framed byte stream from the host: magic byte, 16-bit big-endian word count, then 4*N program bytes.
- Emits the start/valid/end pulse sequence that the fetch stage consumes to fill instruction memory.

Parameters:
- MAGIC, 8'h99, frame-start byte recognised in IDLE.
- LEN_WIDTH, 16, width of word-count field and internal counters; the header is always 2 bytes.
- TIMEOUT_CYCLES, 1000000, idle-byte limit; used only with LOADER_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- input_data  out  8  byte to loader, registered
- input_valid  out  1  one-cycle strobe per program byte
- input_start  out  1  one-cycle pulse opening a load
- input_end  out  1  one-cycle pulse closing a load
- busy  out  1  high from magic accept until input_end cycle inclusive
- error  out  1  sticky; cleared on next accepted MAGIC
- done  out  1  one-cycle pulse coincident with a normal input_end

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; all outputs 0; counters and skid register cleared.
  - Reset mid-load abandons the frame silently; no input_end is emitted.
- All outputs are registered. Mutual exclusion: at most one of input_start, input_valid, input_end is high in any cycle.
- States: IDLE, LEN_HI, LEN_LO, START, DATA, END.
- IDLE:
  - rx_valid with rx_data==MAGIC -> LEN_HI; busy<=1; error<=0.
  - Any other byte is discarded.
- LEN_HI: on rx_valid, count[15:8] <= rx_data -> LEN_LO.
- LEN_LO:
  - On rx_valid, count[7:0] <= rx_data -> START.
  - Byte target = {count,2'b00}, held in LEN_WIDTH+2 bits so there is no overflow.
- START:
  - input_start=1 for exactly one cycle, then DATA.
  - If target==0, go to END instead.
- DATA:
  - First input_valid is never earlier than the cycle after input_start; the consumer enables its loader one cycle after start.
  - Each rx_valid produces input_valid=1 with input_data=rx_data on the next cycle; latency is 1 cycle.
  - A byte arriving during the START cycle is held in a 1-entry skid register and emitted in the first DATA cycle.
  - rx_valid may be asserted every cycle; throughput is 1 byte/cycle.
  - Byte counter increments per emitted byte. When the counter reaches target, go to END; the last input_valid is in the preceding cycle.
- END:
  - input_end=1 for one cycle; done=1 unless aborted; busy<=0 on the next cycle; return to IDLE.
  - rx bytes arriving in END are discarded, including a MAGIC byte.
- An rx_valid in LEN_HI/LEN_LO/DATA is never dropped.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on every rx_valid and while in IDLE.
  - In LEN_HI/LEN_LO/DATA, reaching TIMEOUT_CYCLES goes to END with error<=1 and done=0.
  - A load interrupted in LEN_HI/LEN_LO has seen no input_start and returns directly to IDLE with error=1, emitting no input_end.
- Undefined: no counter; the block waits indefinitely; error is never set.

Decomposition:
- Package loader_pkg:
  - state enum loader_state_t;
  - LOADER_MAGIC default constant;
  - LOADER_HDR_BYTES=3.
- No sub-module; the timeout counter stays inline under the macro.

Test Plan:
- Frame 99 00 01 DE AD BE EF at 1 byte/4 cycles:
  - input_start once;
  - four input_valid with DE,AD,BE,EF in order;
  - input_end 1 cycle after the last valid;
  - done=1; error=0.
- Back-to-back rx_valid every cycle, N=2:
  - first byte arrives in the START cycle and is held in skid;
  - exactly 8 valids, no gaps, correct order;
  - start, valid and end never overlap.
- N=0 (99 00 00): input_start, then input_end in the next cycle; zero valids; done=1.
- Garbage 12 34 before 99:
  - no output until the magic byte;
  - the 12/34 bytes never reach input_data.
- reset_n pulsed low after 2 of 8 data bytes:
  - outputs go to 0 immediately (async);
  - IDLE; no input_end;
  - a subsequent full frame loads correctly.
- LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=50, stall after 3 of 4 bytes: input_end at 50 idle cycles; error=1; done=0; next 99 clears error.
